// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
//   Receive side of the 4:1 TDM link. It deserialises a framed serial stream
//   into four parallel channel words a/b/c/d, sent in slot order 00,01,10,11
//   with each word MSB first. The block hunts for the frame marker and then
//   tracks the slot and bit position. A complete frame is handed over
//   atomically: a..d all update on the same edge.
//
//   Optional feature macro: TDM_DEMUX_PARITY_EN
//     When defined, one even-parity bit follows slot d. It covers all data
//     bits of the frame. A bad frame pulses par_err instead of frame_valid,
//     a..d keep their old values, and the receiver stays locked.
//     When not defined, the frame has no parity bit and par_err is tied 0.
//
// Parameters
//   SAMPLE_W     bits per channel word
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   en           bit strobe; din/sync are sampled only when en=1
//   sync         frame marker, high with the first bit of slot a
//   din          serial data
//   a,b,c,d      channel words from the last good frame (registered)
//   slot         slot currently being received (0 while hunting)
//   frame_valid  1-cycle pulse: a..d were just updated
//   locked       1 while the receiver is in RUN
//   sync_err     1-cycle pulse: sync missing at a frame start, or early
//   par_err      1-cycle pulse: parity failure (0 without the macro)
// -----------------------------------------------------------------------------
module tdm_demux4 #(
  parameter int SAMPLE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sync,
  input  logic                din,
  output logic [SAMPLE_W-1:0] a,
  output logic [SAMPLE_W-1:0] b,
  output logic [SAMPLE_W-1:0] c,
  output logic [SAMPLE_W-1:0] d,
  output logic [1:0]          slot,
  output logic                frame_valid,
  output logic                locked,
  output logic                sync_err,
  output logic                par_err
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          slot_q, slot_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;      // bits already received in this slot
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] stage_q [4];       // completed words of the current frame
  logic [SAMPLE_W-1:0] stage_d [4];
  logic [SAMPLE_W-1:0] word_q [4];        // words presented on a..d
  logic [SAMPLE_W-1:0] word_d [4];
  logic                fv_q, fv_d;
  logic                se_q, se_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic                pe_q, pe_d;
  logic                par_q, par_d;      // running XOR of the frame's data bits
  logic                pphase_q, pphase_d; // next bit is the parity bit
`endif

  // Per-bit decode helpers
  logic                take_bit;   // this strobe carries a frame bit
  logic                new_frame;  // this bit is bit 0 of slot a
  logic                exp_start;  // a frame start is due at this bit
  logic [1:0]          eff_slot;
  logic [CNT_W-1:0]    eff_cnt;
  logic [SAMPLE_W:0]   shift_ext;
  logic [SAMPLE_W-1:0] shifted;
`ifdef TDM_DEMUX_PARITY_EN
  logic                eff_pphase;
  logic                eff_par;
`endif

  // NOTE: every signal this block writes gets a default first. A path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    stage_d   = stage_q;
    word_d    = word_q;
    fv_d      = 1'b0;
    se_d      = 1'b0;
    take_bit  = 1'b0;
    new_frame = 1'b0;
    exp_start = (slot_q == 2'd0) && (cnt_q == '0);
`ifdef TDM_DEMUX_PARITY_EN
    pe_d      = 1'b0;
    par_d     = par_q;
    pphase_d  = pphase_q;
    exp_start = exp_start && !pphase_q;
`endif

    // Classify the strobed bit. The rest of this block handles it.
    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            take_bit  = 1'b1;
            new_frame = 1'b1;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (exp_start && !sync) begin
            // The marker is missing. Drop the bit and hunt again. a..d hold.
            se_d    = 1'b1;
            state_d = HUNT;
            slot_d  = 2'd0;
            cnt_d   = '0;
          end else begin
            take_bit  = 1'b1;
            new_frame = sync;
            // The marker came early: the partial frame is thrown away.
            se_d      = sync && !exp_start;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // A new frame restarts the bit position at slot a, bit 0.
    eff_slot  = new_frame ? 2'd0 : slot_q;
    eff_cnt   = new_frame ? '0 : cnt_q;
    shift_ext = {shift_q, din};
    shifted   = shift_ext[SAMPLE_W-1:0];
`ifdef TDM_DEMUX_PARITY_EN
    eff_pphase = new_frame ? 1'b0 : pphase_q;
    eff_par    = new_frame ? 1'b0 : par_q;
`endif

    if (take_bit) begin
`ifdef TDM_DEMUX_PARITY_EN
      if (eff_pphase) begin
        // Parity bit: the frame ends here either way.
        pphase_d = 1'b0;
        slot_d   = 2'd0;
        cnt_d    = '0;
        par_d    = 1'b0;
        if (eff_par ^ din) begin
          pe_d = 1'b1;
        end else begin
          word_d = stage_q;
          fv_d   = 1'b1;
        end
      end else begin
        par_d   = eff_par ^ din;
`endif
        shift_d = shifted;
        slot_d  = eff_slot;
        if (eff_cnt == LAST_BIT) begin
          stage_d[eff_slot] = shifted;
          cnt_d             = '0;
          if (eff_slot == 2'd3) begin
`ifdef TDM_DEMUX_PARITY_EN
            // slot stays 3 until the parity bit closes the frame.
            pphase_d = 1'b1;
`else
            // Frame end: all four words load together.
            word_d = stage_d;
            fv_d   = 1'b1;
            slot_d = 2'd0;
`endif
          end else begin
            slot_d = eff_slot + 2'd1;
          end
        end else begin
          cnt_d = eff_cnt + 1'b1;
        end
`ifdef TDM_DEMUX_PARITY_EN
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. The staging
  // and output words are reset as well: reset must clear a..d, and a clean
  // start keeps X out of the first frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      cnt_q   <= '0;
      shift_q <= '0;
      for (int i = 0; i < 4; i++) begin
        stage_q[i] <= '0;
        word_q[i]  <= '0;
      end
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      pe_q     <= 1'b0;
      par_q    <= 1'b0;
      pphase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      stage_q <= stage_d;
      word_q  <= word_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
`ifdef TDM_DEMUX_PARITY_EN
      pe_q     <= pe_d;
      par_q    <= par_d;
      pphase_q <= pphase_d;
`endif
    end
  end

  assign a           = word_q[0];
  assign b           = word_q[1];
  assign c           = word_q[2];
  assign d           = word_q[3];
  assign slot        = slot_q;
  assign frame_valid = fv_q;
  assign locked      = (state_q == RUN);
  assign sync_err    = se_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err     = pe_q;
`else
  assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux4
//   Directed self-checking bench for tdm_demux4 with SAMPLE_W=4. The stimulus
//   is applied one bit per clock. Outputs are sampled 1 time unit after the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       sync;
  logic       din;
  logic [3:0] a, b, c, d;
  logic [1:0] slot;
  logic       frame_valid, locked, sync_err, par_err;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.SAMPLE_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync        (sync),
    .din         (din),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .slot        (slot),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .par_err     (par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one strobe and sample just after the edge that consumes it.
  task automatic send_bit(input logic s, input logic bd, input logic e);
    en   = e;
    sync = s;
    din  = bd;
    @(posedge clk);
    #1;
  endtask

  // One frame with sync on its first bit. With gap=1, an en=0 cycle comes
  // before each bit after the first. In that cycle sync/din are driven to 1,
  // and the DUT must ignore them.
  task automatic send_frame(input logic [3:0] w0, input logic [3:0] w1,
                            input logic [3:0] w2, input logic [3:0] w3,
                            input logic gap, input logic exp_se,
                            input logic [3:0] hold_a, input logic bad_par);
    logic [15:0] frame;
    frame = {w0, w1, w2, w3};
    for (int i = 15; i >= 0; i--) begin
      if (gap && i != 15) send_bit(1'b1, 1'b1, 1'b0);
      send_bit(i == 15, frame[i], 1'b1);
      if (i == 15) begin
        check("sync_err_at_start", sync_err, exp_se);
        check("a_held_at_start", a, hold_a);
      end
      if (i % 4 == 3) check("slot_first_bit", slot, 32'((15 - i) / 4));
    end
`ifdef TDM_DEMUX_PARITY_EN
    if (gap) send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, (^frame) ^ bad_par, 1'b1);
`endif
  endtask

  task automatic check_words(input string tag, input logic [15:0] exp);
    check(tag, {a, b, c, d}, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sync  = 1'b0;
    din   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_words", {a, b, c, d}, 16'h0000);
    check("reset_flags", {slot, frame_valid, locked, sync_err, par_err}, 6'b0);
    rst_n = 1'b1;
    send_bit(1'b0, 1'b1, 1'b1);   // junk bit without sync: still hunting
    check("hunt_unlocked", locked, 1'b0);

    // Single frame A,5,C,3
    send_frame(4'hA, 4'h5, 4'hC, 4'h3, 1'b0, 1'b0, 4'h0, 1'b0);
    check("f1_valid", frame_valid, 1'b1);
    check_words("f1_words", 16'hA5C3);
    check("f1_locked", locked, 1'b1);
    check("f1_no_err", {sync_err, par_err}, 2'b00);
    send_bit(1'b0, 1'b0, 1'b0);
    check("f1_valid_pulse_ends", frame_valid, 1'b0);

    // Two back-to-back frames while en toggles
    send_frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b0, 4'hA, 1'b0);
    check("f2_valid", frame_valid, 1'b1);
    check_words("f2_words", 16'h1234);
    send_frame(4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 4'h1, 1'b0);
    check("f3_valid", frame_valid, 1'b1);
    check_words("f3_words", 16'hF0F0);

    // Early sync: 6 bits of 9,9,.. then a new frame starts on bit 6
    send_bit(1'b1, 1'b1, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b0, 1'b1, 1'b1);
    send_bit(1'b0, 1'b1, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    check("partial_slot", slot, 2'd1);
    send_frame(4'h6, 4'h7, 4'h8, 4'hE, 1'b0, 1'b1, 4'hF, 1'b0);
    check("f4_valid", frame_valid, 1'b1);
    check_words("f4_words", 16'h678E);

    // Sync missing at the expected start: lock is lost, words are held
    send_bit(1'b0, 1'b1, 1'b1);
    check("miss_sync_err", sync_err, 1'b1);
    check("miss_unlocked", locked, 1'b0);
    check_words("miss_words_held", 16'h678E);
    send_bit(1'b0, 1'b1, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    check("hunt_quiet", {locked, sync_err, slot}, 4'b0000);
    send_frame(4'hB, 4'hD, 4'h2, 4'h7, 1'b0, 1'b0, 4'h6, 1'b0);
    check("f5_valid", frame_valid, 1'b1);
    check_words("f5_words", 16'hBD27);
    check("f5_locked", locked, 1'b1);

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity: par_err instead of frame_valid, words and lock kept
    send_frame(4'hA, 4'h5, 4'hC, 4'h3, 1'b0, 1'b0, 4'hB, 1'b1);
    check("par_err_pulse", par_err, 1'b1);
    check("par_no_valid", frame_valid, 1'b0);
    check_words("par_words_held", 16'hBD27);
    check("par_locked", locked, 1'b1);
`endif

    // Asynchronous reset in the middle of a frame
    send_bit(1'b1, 1'b1, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b0, 1'b1, 1'b1);
    send_bit(1'b0, 1'b1, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    check("pre_reset_locked", locked, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_words", {a, b, c, d}, 16'h0000);
    check("async_reset_flags", {slot, frame_valid, locked, sync_err, par_err}, 6'b0);
    rst_n = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
